// File: rtl/bram_stream_reader_pkg.sv
// rtl/bram_stream_reader_pkg.sv - shared state encoding and output FIFO sizing for bram_stream_reader
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 3;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/stream_skid_fifo.sv
// rtl/stream_skid_fifo.sv - small circular FIFO holding {last,data} beats ahead of the master stream
module stream_skid_fifo #(
  parameter int W     = 73,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [IW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(DEPTH - 1)) ? '0 : i + IW'(1);
  endfunction

  // The caller's credit rule guarantees push never lands on a full FIFO.
  assign do_pop = pop && (cnt_q != '0);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = next_idx(wr_q);
    end
    if (do_pop) begin
      rd_d = next_idx(rd_q);
    end
    cnt_d = cnt_q + CW'(push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_q];
  assign valid = (cnt_q != '0);
  assign count = cnt_q;

endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - reads a contiguous BRAM range and streams it out with last on the final word
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int WIDTH  = 72,
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [WIDTH-1:0]  bram_rdata,
  output logic [WIDTH-1:0]  ms_data,
  output logic              ms_valid,
  input  logic              ms_ready,
  output logic              ms_last,
  output logic              busy,
  output logic              done
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic                inflight_q, inflight_d;
  logic                last_pipe_q, last_pipe_d;
  logic                done_q, done_d;

  logic [WIDTH:0]      fifo_dout;
  logic                fifo_valid;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                pop;
  logic                issue;
  logic [2:0]          occ;

  assign pop = fifo_valid && ms_ready;
  // Slots already spoken for once this cycle's push/pop settle; a new read needs one more.
  assign occ   = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign issue = (state_q == ST_ISSUE) && (occ < 3'(FIFO_DEPTH));

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    inflight_d  = issue;
    last_pipe_d = issue && (remaining_q == LEN_W'(1));
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          rd_ptr_d    = cmd_base;
          remaining_d = cmd_len;
          if (cmd_len == '0) done_d  = 1'b1;
          else               state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && ms_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      last_pipe_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      last_pipe_q <= last_pipe_d;
      done_q      <= done_d;
    end
  end

  stream_skid_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (inflight_q),
    .din    ({last_pipe_q, bram_rdata}),
    .pop    (pop),
    .dout   (fifo_dout),
    .valid  (fifo_valid),
    .count  (fifo_count)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign bram_en   = issue;
  assign bram_addr = rd_ptr_q;
  assign ms_data   = fifo_dout[WIDTH-1:0];
  assign ms_valid  = fifo_valid;
  assign ms_last   = fifo_valid && fifo_dout[WIDTH];
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule
